divisor_restauracion: RTL and testbench
=======================================

// Module: divisor_restauracion
// PURPOSE
//  Sequential N-bit restoring divider. It is the inverse datapath of the shift-add multiplier.
//  It uses A/Q/M shift registers, an add/sub unit and a control FSM.
//  Each iteration shifts {A,Q} left, trial-subtracts M and produces one quotient bit.
//  It sits beside the multiplier and uses the same start/done handshake toward the top-level controller.
// PARAMETERS
//  N  4  operand, quotient and remainder width in bits (N>=2)
// PORTS
//  clk        in   1  single clock; every register updates on its rising edge
//  reset      in   1  synchronous, active-high reset
//  inicio     in   1  start request; sampled only in state IDLE
//  dividendo  in   N  dividend, captured at the edge that accepts inicio
//  divisor    in   N  divisor, captured at the same edge
//  cociente   out  N  quotient, registered; holds its value until the next completion
//  resto      out  N  remainder, registered; holds its value until the next completion
//  ocupado    out  1  high in every state except IDLE
//  fin        out  1  one-cycle pulse: cociente and resto are valid
//  div_cero   out  1  registered with the result; 1 if the captured divisor == 0
// BEHAVIOUR
//  - Reset: state=IDLE, A=0, Q=0, M=0, cnt=0; cociente=0, resto=0, ocupado=0, fin=0, div_cero=0.
//    Reset mid-operation aborts the division. No fin is produced for the aborted operation.
//  - FSM: IDLE -> CARGA -> ITERA (N cycles) [-> SIGNO] -> FIN -> IDLE.
//  - IDLE: if inicio=1 at edge k, capture the operands and go to CARGA.
//  - CARGA (1 cycle): A<=0 (N+1 bits), Q<=dividendo, M<={1'b0,divisor}, cnt<=N.
//  - ITERA: {A,Q} <= {A,Q}<<1, then D = A' - M over N+1 bits.
//    If D[N]=1: restore (A keeps the shifted value) and Q[0]<=0.
//    Otherwise: A<=D and Q[0]<=1.
//    cnt decrements every cycle; leave ITERA when cnt reaches 1.
//  - FIN (1 cycle): cociente<=Q, resto<=A[N-1:0], div_cero<=(M==0), fin=1.
//  - Latency: inicio sampled at edge k -> fin high in the cycle after edge k+N+2 (unsigned).
//  - inicio while ocupado=1 is ignored and is not queued.
//    If inicio is held high, a new division starts on the edge where the state is back in IDLE.
//  - Divide by zero: no special path. Result is cociente = all ones, resto = dividendo, div_cero=1.
//  - Arithmetic is unsigned modulo 2^(N+1) inside the A path. The output is never wider than N.
// CONFIGURATION
//  DIV_CON_SIGNO_EN defined:
//   - Operands are two's complement. CARGA loads the magnitudes |dividendo| and |divisor|.
//   - A SIGNO state (1 cycle) follows ITERA. It negates Q if the operand signs differ.
//     It negates A if the dividend is negative.
//   - Quotient truncates toward zero; the remainder takes the sign of the dividend.
//   - Latency grows by 1 cycle.
//   - -2^(N-1) / -1 wraps to -2^(N-1) with remainder 0.
//  DIV_CON_SIGNO_EN undefined: unsigned only; no SIGNO state exists.
// STRUCTURE
//  - Shared package/include div_pkg: state encoding constants (IDLE, CARGA, ITERA, SIGNO, FIN).
//    Also the counter width localparam CW = $clog2(N+1).
//  - One sub-module, restador_n: (N+1)-bit combinational A-M subtractor with a borrow/sign output.
//  - The FSM, counter and A/Q/M registers live in divisor_restauracion.
// TESTING (N=4)
//  - 13/3 unsigned -> fin pulse at k+6; cociente=4, resto=1, div_cero=0.
//  - 7/0 -> cociente=15, resto=7, div_cero=1.
//  - 15/1 and 2/9 -> (15,0) and (0,2).
//    Check that ocupado=1 from k+1 until the fin cycle inclusive.
//  - inicio held high for 20 cycles with 9/2 -> a back-to-back result (4,1) each time.
//    fin never lasts more than one cycle.
//  - reset pulsed at k+3 during 13/3 -> all outputs 0 next cycle, no fin.
//    A new 6/4 then gives (1,2).
//  - DIV_CON_SIGNO_EN: -7/2 -> cociente=4'b1101, resto=4'b1111. -8/-1 -> cociente=4'b1000, resto=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM states and counter width.
// DIV_CON_SIGNO_EN adds the SIGNO state used by the two's-complement build.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CARGA,
    ITERA,
`ifdef DIV_CON_SIGNO_EN
    SIGNO,
`endif
    FIN
  } estado_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned CW = cnt_width(4);

endpackage

// File: rtl/restador_n.sv
// (N+1)-bit combinational trial subtractor A - M; neg is the sign/borrow bit.
module restador_n #(
  parameter int N = 4
) (
  input  logic [N:0] a,
  input  logic [N:0] b,
  output logic [N:0] diff,
  output logic       neg
);

  always_comb begin
    diff = a - b;
    neg  = diff[N];
  end

endmodule

// File: rtl/divisor_restauracion.sv
// Sequential N-bit restoring divider with start/done handshake.
// Define DIV_CON_SIGNO_EN for two's-complement operands (adds one SIGNO cycle).
module divisor_restauracion
  import div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inicio,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] cociente,
  output logic [N-1:0] resto,
  output logic         ocupado,
  output logic         fin,
  output logic         div_cero
);

  localparam int unsigned CWN = cnt_width(N);

  estado_t        estado;
  logic [N:0]     a;
  logic [N:0]     m;
  logic [N-1:0]   q;
  logic [CWN-1:0] cnt;
  logic [N:0]     a_sh;
  logic [N:0]     d;
  logic           d_neg;
`ifdef DIV_CON_SIGNO_EN
  logic           neg_q;
  logic           neg_r;
`endif

  assign a_sh = {a[N-1:0], q[N-1]};

  restador_n #(.N(N)) u_restador (
    .a    (a_sh),
    .b    (m),
    .diff (d),
    .neg  (d_neg)
  );

  // Operands are latched into Q/M on acceptance so CARGA sees stable values
  // even if the inputs change; ocupado stays high through the fin cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= IDLE;
      a        <= '0;
      q        <= '0;
      m        <= '0;
      cnt      <= '0;
      cociente <= '0;
      resto    <= '0;
      ocupado  <= 1'b0;
      fin      <= 1'b0;
      div_cero <= 1'b0;
`ifdef DIV_CON_SIGNO_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      fin <= 1'b0;
      case (estado)
        IDLE: begin
          if (inicio) begin
            q       <= dividendo;
            m       <= {1'b0, divisor};
            ocupado <= 1'b1;
            estado  <= CARGA;
          end else begin
            ocupado <= 1'b0;
          end
        end
        CARGA: begin
          a   <= '0;
          cnt <= CWN'(N);
`ifdef DIV_CON_SIGNO_EN
          q     <= q[N-1] ? -q : q;
          m     <= {1'b0, (m[N-1] ? -m[N-1:0] : m[N-1:0])};
          neg_q <= q[N-1] ^ m[N-1];
          neg_r <= q[N-1];
`endif
          estado <= ITERA;
        end
        ITERA: begin
          a   <= d_neg ? a_sh : d;
          q   <= {q[N-2:0], ~d_neg};
          cnt <= cnt - 1'b1;
          if (cnt == CWN'(1)) begin
`ifdef DIV_CON_SIGNO_EN
            estado <= SIGNO;
`else
            estado <= FIN;
`endif
          end
        end
`ifdef DIV_CON_SIGNO_EN
        SIGNO: begin
          if (neg_q) q <= -q;
          if (neg_r) a <= -a;
          estado <= FIN;
        end
`endif
        FIN: begin
          cociente <= q;
          resto    <= a[N-1:0];
          div_cero <= (m == '0);
          fin      <= 1'b1;
          estado   <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_restauracion.sv
// Self-checking bench for divisor_restauracion (N=4) against an arithmetic model.
module tb_divisor_restauracion;

  localparam int N = 4;
`ifdef DIV_CON_SIGNO_EN
  localparam int LAT = N + 3;
`else
  localparam int LAT = N + 2;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         inicio;
  logic [N-1:0] dividendo;
  logic [N-1:0] divisor;
  logic [N-1:0] cociente;
  logic [N-1:0] resto;
  logic         ocupado;
  logic         fin;
  logic         div_cero;

  int checks = 0;
  int errors = 0;

  divisor_restauracion #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .inicio    (inicio),
    .dividendo (dividendo),
    .divisor   (divisor),
    .cociente  (cociente),
    .resto     (resto),
    .ocupado   (ocupado),
    .fin       (fin),
    .div_cero  (div_cero)
  );

  always #5 clk = ~clk;

  // Reference: {quotient, remainder} from plain integer division.
  function automatic logic [7:0] ref_div(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] rq, rr;
`ifdef DIV_CON_SIGNO_EN
    int sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sy == 0) begin
      rq = (sx < 0) ? 4'h1 : 4'hF;
      rr = x;
    end else begin
      rq = 4'(sx / sy);
      rr = 4'(sx % sy);
    end
`else
    if (y == 0) begin
      rq = 4'hF;
      rr = x;
    end else begin
      rq = x / y;
      rr = x % y;
    end
`endif
    return {rq, rr};
  endfunction

  // Launch one division and wait (bounded) for fin; lat=0 means timeout.
  task automatic run_div(input logic [3:0] x, input logic [3:0] y,
                         output int lat, output logic ocup_ok);
    @(negedge clk);
    dividendo = x;
    divisor   = y;
    inicio    = 1'b1;
    @(posedge clk);
    #1 inicio = 1'b0;
    lat     = 0;
    ocup_ok = ocupado;
    for (int i = 1; i <= 3 * LAT; i++) begin
      @(posedge clk);
      #1;
      if (ocupado !== 1'b1) ocup_ok = 1'b0;
      if (fin === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    inicio = 1'b0;
    dividendo = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cociente !== 4'h0) begin errors++; $display("FAIL reset_cociente got=%h exp=0", cociente); end
    checks++; if (resto !== 4'h0) begin errors++; $display("FAIL reset_resto got=%h exp=0", resto); end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got=%b exp=0", ocupado); end
    checks++; if (fin !== 1'b0) begin errors++; $display("FAIL reset_fin got=%b exp=0", fin); end
    checks++; if (div_cero !== 1'b0) begin errors++; $display("FAIL reset_div_cero got=%b exp=0", div_cero); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed;
`ifdef DIV_CON_SIGNO_EN
    logic [3:0] xs[2] = '{4'b1001, 4'b1000};
    logic [3:0] ys[2] = '{4'b0010, 4'b1111};
    logic [3:0] qs[2] = '{4'b1101, 4'b1000};
    logic [3:0] rs[2] = '{4'b1111, 4'b0000};
    logic       zs[2] = '{1'b0, 1'b0};
`else
    logic [3:0] xs[4] = '{4'd13, 4'd7, 4'd15, 4'd2};
    logic [3:0] ys[4] = '{4'd3, 4'd0, 4'd1, 4'd9};
    logic [3:0] qs[4] = '{4'd4, 4'd15, 4'd15, 4'd0};
    logic [3:0] rs[4] = '{4'd1, 4'd7, 4'd0, 4'd2};
    logic       zs[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
`endif
    int lat;
    logic ok;
    foreach (xs[i]) begin
      run_div(xs[i], ys[i], lat, ok);
      checks++; if (lat != LAT) begin errors++; $display("FAIL dir_latency %0d/%0d got=%0d exp=%0d", xs[i], ys[i], lat, LAT); end
      checks++; if (cociente !== qs[i]) begin errors++; $display("FAIL dir_cociente %h/%h got=%h exp=%h", xs[i], ys[i], cociente, qs[i]); end
      checks++; if (resto !== rs[i]) begin errors++; $display("FAIL dir_resto %h/%h got=%h exp=%h", xs[i], ys[i], resto, rs[i]); end
      checks++; if (div_cero !== zs[i]) begin errors++; $display("FAIL dir_div_cero %h/%h got=%b exp=%b", xs[i], ys[i], div_cero, zs[i]); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL dir_ocupado %h/%h got=0 exp=1 while busy", xs[i], ys[i]); end
      @(posedge clk);
      #1;
      checks++; if (fin !== 1'b0 || ocupado !== 1'b0) begin errors++; $display("FAIL dir_idle_after fin=%b ocupado=%b exp=0,0", fin, ocupado); end
    end
  endtask

  task automatic test_random;
    int lat;
    logic ok;
    logic [3:0] x, y;
    logic [7:0] e;
    for (int i = 0; i < 40; i++) begin
      x = 4'($urandom);
      y = (i % 10 == 0) ? 4'h0 : 4'($urandom);
      e = ref_div(x, y);
      run_div(x, y, lat, ok);
      checks++; if (lat != LAT) begin errors++; $display("FAIL rnd_latency %h/%h got=%0d exp=%0d", x, y, lat, LAT); end
      checks++; if (cociente !== e[7:4]) begin errors++; $display("FAIL rnd_cociente %h/%h got=%h exp=%h", x, y, cociente, e[7:4]); end
      checks++; if (resto !== e[3:0]) begin errors++; $display("FAIL rnd_resto %h/%h got=%h exp=%h", x, y, resto, e[3:0]); end
      checks++; if (div_cero !== (y == 4'h0)) begin errors++; $display("FAIL rnd_div_cero %h/%h got=%b exp=%b", x, y, div_cero, (y == 4'h0)); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    int nfin = 0;
    logic prev = 1'b0;
    e = ref_div(4'd9, 4'd2);
    @(negedge clk);
    dividendo = 4'd9;
    divisor   = 4'd2;
    inicio    = 1'b1;
    for (int i = 0; i < 20 + 3 * LAT; i++) begin
      @(posedge clk);
      #1;
      if (i == 19) inicio = 1'b0;
      if (fin === 1'b1) begin
        nfin++;
        checks++; if (cociente !== e[7:4] || resto !== e[3:0]) begin errors++; $display("FAIL b2b_result got=(%h,%h) exp=(%h,%h)", cociente, resto, e[7:4], e[3:0]); end
        checks++; if (prev === 1'b1) begin errors++; $display("FAIL b2b_fin_width got=2+ cycles exp=1"); end
      end
      prev = fin;
    end
    checks++; if (nfin != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", nfin); end
  endtask

  task automatic test_reset_abort;
    int nfin = 0;
    int lat;
    logic ok;
    logic [7:0] e;
    @(negedge clk);
    dividendo = 4'd13;
    divisor   = 4'd3;
    inicio    = 1'b1;
    @(posedge clk);
    #1 inicio = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if ({cociente, resto, ocupado, fin, div_cero} !== '0) begin errors++; $display("FAIL abort_outputs got=%h,%h,%b,%b,%b exp=all 0", cociente, resto, ocupado, fin, div_cero); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3 * LAT; i++) begin
      @(posedge clk);
      #1;
      if (fin === 1'b1) nfin++;
    end
    checks++; if (nfin != 0) begin errors++; $display("FAIL abort_no_fin got=%0d exp=0", nfin); end
    e = ref_div(4'd6, 4'd4);
    run_div(4'd6, 4'd4, lat, ok);
    checks++; if (lat != LAT || cociente !== e[7:4] || resto !== e[3:0]) begin errors++; $display("FAIL abort_next lat=%0d got=(%h,%h) exp lat=%0d (%h,%h)", lat, cociente, resto, LAT, e[7:4], e[3:0]); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
